// File: rtl/ecc_telemetry_collector.sv
// ECC telemetry collector: windowed SBE/DBE statistics, stuck-syndrome detection,
// one summary record per window over valid/ready, plus firmware alerts.
module ecc_telemetry_collector #(
  parameter int ECC_WIDTH        = 8,
  parameter int CNT_WIDTH        = 16,
  parameter int WINDOW_CYCLES    = 1024,
  parameter int SBE_ALERT_THRESH = 16,
  parameter int REPEAT_THRESH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ECC_WIDTH-1:0] ml_syndrome,
  input  logic                 ml_err_sbe,
  input  logic                 ml_err_dbe,
  input  logic                 clear,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [CNT_WIDTH-1:0] rec_sbe_cnt,
  output logic [CNT_WIDTH-1:0] rec_dbe_cnt,
  output logic [ECC_WIDTH-1:0] rec_syndrome,
  output logic                 rec_stuck,
  output logic                 rec_overflow,
  output logic                 sbe_alert,
  output logic                 dbe_alert,
  output logic [7:0]           drop_cnt
);
  localparam int TW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int RW = $clog2(REPEAT_THRESH + 1);
  localparam logic [TW-1:0]        TC     = TW'(WINDOW_CYCLES - 1);
  localparam logic [RW-1:0]        REP_TH = RW'(REPEAT_THRESH);
  localparam logic [CNT_WIDTH-1:0] SBE_TH = CNT_WIDTH'(SBE_ALERT_THRESH);

  typedef enum logic {EMPTY, FULL} st_e;

  st_e                  st_q;
  logic [TW-1:0]        timer_q;
  logic [CNT_WIDTH-1:0] sbe_cnt_q, dbe_cnt_q, sbe_cnt_d, dbe_cnt_d;
  logic                 ovf_q, ovf_d, stuck_q, stuck_d;
  logic [ECC_WIDTH-1:0] last_syn_q, last_syn_d;
  logic [RW-1:0]        rep_q, rep_d;
  logic                 sbe_alert_q, dbe_alert_q;
  logic [CNT_WIDTH-1:0] rec_sbe_q, rec_dbe_q;
  logic [ECC_WIDTH-1:0] rec_syn_q;
  logic                 rec_stuck_q, rec_ovf_q;
  logic [7:0]           drop_q;

  logic sbe, dbe, tc, close, sbe_sat, dbe_sat, syn_hit, alert_fire;

  always_comb begin
    // Events coincident with clear are discarded from all statistics.
    sbe     = ml_err_sbe & ~ml_err_dbe & ~clear;
    dbe     = ml_err_dbe & ~clear;
    tc      = (timer_q == TC);
    close   = tc & ~clear;
    sbe_sat = &sbe_cnt_q;
    dbe_sat = &dbe_cnt_q;

    sbe_cnt_d = sbe_cnt_q + CNT_WIDTH'(sbe & ~sbe_sat);
    dbe_cnt_d = dbe_cnt_q + CNT_WIDTH'(dbe & ~dbe_sat);
    ovf_d     = ovf_q | (sbe & sbe_sat) | (dbe & dbe_sat);

    syn_hit    = (ml_syndrome == last_syn_q) && (rep_q != '0);
    rep_d      = rep_q;
    last_syn_d = last_syn_q;
    if (sbe) begin
      if (syn_hit) begin
        rep_d = (rep_q == REP_TH) ? rep_q : rep_q + RW'(1);
      end else begin
        last_syn_d = ml_syndrome;
        rep_d      = RW'(1);
      end
    end
    stuck_d = stuck_q | (sbe && (rep_d == REP_TH));

    alert_fire = sbe & ~sbe_sat & (sbe_cnt_d == SBE_TH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= EMPTY;
      timer_q     <= '0;
      sbe_cnt_q   <= '0;
      dbe_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      stuck_q     <= 1'b0;
      last_syn_q  <= '0;
      rep_q       <= '0;
      sbe_alert_q <= 1'b0;
      dbe_alert_q <= 1'b0;
      rec_sbe_q   <= '0;
      rec_dbe_q   <= '0;
      rec_syn_q   <= '0;
      rec_stuck_q <= 1'b0;
      rec_ovf_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      if (clear) begin
        timer_q     <= '0;
        sbe_cnt_q   <= '0;
        dbe_cnt_q   <= '0;
        ovf_q       <= 1'b0;
        stuck_q     <= 1'b0;
        last_syn_q  <= '0;
        rep_q       <= '0;
        sbe_alert_q <= 1'b0;
        dbe_alert_q <= ml_err_dbe;
        drop_q      <= '0;
      end else begin
        timer_q     <= tc ? '0 : timer_q + TW'(1);
        sbe_cnt_q   <= close ? '0 : sbe_cnt_d;
        dbe_cnt_q   <= close ? '0 : dbe_cnt_d;
        ovf_q       <= close ? 1'b0 : ovf_d;
        stuck_q     <= close ? 1'b0 : stuck_d;
        last_syn_q  <= last_syn_d;
        rep_q       <= rep_d;
        sbe_alert_q <= alert_fire;
        dbe_alert_q <= dbe_alert_q | dbe;
        if (close && st_q == FULL && !rec_ready && drop_q != 8'hFF)
          drop_q <= drop_q + 8'd1;
      end

      // close is already masked by clear, so a pending record survives clear.
      if (close && (st_q == EMPTY || rec_ready)) begin
        st_q        <= FULL;
        rec_sbe_q   <= sbe_cnt_d;
        rec_dbe_q   <= dbe_cnt_d;
        rec_syn_q   <= last_syn_d;
        rec_stuck_q <= stuck_d;
        rec_ovf_q   <= ovf_d;
      end else if (!close && st_q == FULL && rec_ready) begin
        st_q <= EMPTY;
      end
    end
  end

  assign rec_valid    = (st_q == FULL);
  assign rec_sbe_cnt  = rec_sbe_q;
  assign rec_dbe_cnt  = rec_dbe_q;
  assign rec_syndrome = rec_syn_q;
  assign rec_stuck    = rec_stuck_q;
  assign rec_overflow = rec_ovf_q;
  assign sbe_alert    = sbe_alert_q;
  assign dbe_alert    = dbe_alert_q;
  assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_ecc_telemetry_collector.sv
// Bench for ecc_telemetry_collector: two instances (16- and 32-cycle windows)
// share stimulus and are compared every cycle against a window-level model.
module tb_ecc_telemetry_collector;
  localparam int CW = 4, EW = 8, TH = 3, RT = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0, rst, s_i, d_i, clr, rdy;
  logic [EW-1:0] syn;
  logic          rv[2], stk[2], ovf[2], sa[2], da[2];
  logic [CW-1:0] rs[2], rd[2];
  logic [EW-1:0] ry[2];
  logic [7:0]    dc[2];

  always #5 clk = ~clk;

  ecc_telemetry_collector #(.ECC_WIDTH(EW), .CNT_WIDTH(CW), .WINDOW_CYCLES(16),
    .SBE_ALERT_THRESH(TH), .REPEAT_THRESH(RT)) dut0 (
    .clk(clk), .rst(rst), .ml_syndrome(syn), .ml_err_sbe(s_i), .ml_err_dbe(d_i),
    .clear(clr), .rec_valid(rv[0]), .rec_ready(rdy), .rec_sbe_cnt(rs[0]),
    .rec_dbe_cnt(rd[0]), .rec_syndrome(ry[0]), .rec_stuck(stk[0]),
    .rec_overflow(ovf[0]), .sbe_alert(sa[0]), .dbe_alert(da[0]), .drop_cnt(dc[0]));

  ecc_telemetry_collector #(.ECC_WIDTH(EW), .CNT_WIDTH(CW), .WINDOW_CYCLES(32),
    .SBE_ALERT_THRESH(TH), .REPEAT_THRESH(RT)) dut1 (
    .clk(clk), .rst(rst), .ml_syndrome(syn), .ml_err_sbe(s_i), .ml_err_dbe(d_i),
    .clear(clr), .rec_valid(rv[1]), .rec_ready(rdy), .rec_sbe_cnt(rs[1]),
    .rec_dbe_cnt(rd[1]), .rec_syndrome(ry[1]), .rec_stuck(stk[1]),
    .rec_overflow(ovf[1]), .sbe_alert(sa[1]), .dbe_alert(da[1]), .drop_cnt(dc[1]));

  // Model: unsaturated event counts and syndrome run length; saturation is
  // applied only when a record is published.
  int       m_timer[2], m_nsbe[2], m_ndbe[2], m_run[2], m_drops[2];
  bit [7:0] m_last[2];
  bit       m_stuck[2], m_sa[2], m_da[2], m_rv[2];
  int       e_sbe[2], e_dbe[2];
  bit [7:0] e_syn[2];
  bit       e_stk[2], e_ovf[2];
  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_step(input int k, input int w);
    bit s, close;
    if (rst) begin
      m_timer[k] = 0; m_nsbe[k] = 0; m_ndbe[k] = 0; m_run[k] = 0; m_drops[k] = 0;
      m_last[k] = 0; m_stuck[k] = 0; m_sa[k] = 0; m_da[k] = 0; m_rv[k] = 0;
      e_sbe[k] = 0; e_dbe[k] = 0; e_syn[k] = 0; e_stk[k] = 0; e_ovf[k] = 0;
      return;
    end
    close = 0;
    if (clr) begin
      m_da[k] = d_i; m_timer[k] = 0; m_nsbe[k] = 0; m_ndbe[k] = 0; m_run[k] = 0;
      m_last[k] = 0; m_stuck[k] = 0; m_drops[k] = 0; m_sa[k] = 0;
    end else begin
      s = s_i && !d_i;
      m_sa[k] = 0;
      if (s) begin
        m_nsbe[k]++;
        m_sa[k] = (m_nsbe[k] == TH);
        if (m_run[k] > 0 && syn == m_last[k]) m_run[k]++;
        else begin m_last[k] = syn; m_run[k] = 1; end
        if (m_run[k] >= RT) m_stuck[k] = 1;
      end
      if (d_i) begin m_ndbe[k]++; m_da[k] = 1; end
      close = (m_timer[k] == w - 1);
      m_timer[k] = (m_timer[k] + 1) % w;
    end
    if (close) begin
      if (!m_rv[k] || rdy) begin
        m_rv[k] = 1; e_sbe[k] = sat(m_nsbe[k]); e_dbe[k] = sat(m_ndbe[k]);
        e_syn[k] = m_last[k]; e_stk[k] = m_stuck[k];
        e_ovf[k] = (m_nsbe[k] > CMAX) || (m_ndbe[k] > CMAX);
      end else m_drops[k]++;
      m_nsbe[k] = 0; m_ndbe[k] = 0; m_stuck[k] = 0;
    end else if (m_rv[k] && rdy) m_rv[k] = 0;
  endtask

  task automatic check_all(input int k);
    chk($sformatf("w%0d rec_valid", k), 32'(rv[k]), 32'(m_rv[k]));
    chk($sformatf("w%0d rec_sbe_cnt", k), 32'(rs[k]), 32'(e_sbe[k]));
    chk($sformatf("w%0d rec_dbe_cnt", k), 32'(rd[k]), 32'(e_dbe[k]));
    chk($sformatf("w%0d rec_syndrome", k), 32'(ry[k]), 32'(e_syn[k]));
    chk($sformatf("w%0d rec_stuck", k), 32'(stk[k]), 32'(e_stk[k]));
    chk($sformatf("w%0d rec_overflow", k), 32'(ovf[k]), 32'(e_ovf[k]));
    chk($sformatf("w%0d sbe_alert", k), 32'(sa[k]), 32'(m_sa[k]));
    chk($sformatf("w%0d dbe_alert", k), 32'(da[k]), 32'(m_da[k]));
    chk($sformatf("w%0d drop_cnt", k), 32'(dc[k]),
        32'((m_drops[k] > 255) ? 255 : m_drops[k]));
  endtask

  task automatic drv(input bit s, input bit d, input logic [7:0] y, input bit c,
                     input bit r, input bit rr);
    s_i = s; d_i = d; syn = y; clr = c; rdy = r; rst = rr;
    @(posedge clk);
    model_step(0, 16);
    model_step(1, 32);
    #1;
    check_all(0);
    check_all(1);
  endtask

  int n, n2, saved;

  initial begin
    s_i = 0; d_i = 0; syn = 0; clr = 0; rdy = 1; rst = 1;

    // Reset and idle: two empty records, one cycle each.
    drv(0, 0, 0, 0, 1, 1);
    chk("reset rec_valid", 32'(rv[0]), 0);
    chk("reset drop_cnt", 32'(dc[0]), 0);
    n = 0; n2 = 0;
    for (int i = 0; i < 40; i++) begin
      drv(0, 0, 0, 0, 1, 0);
      n += int'(rv[0]); n2 += int'(sa[0]) + int'(da[0]);
    end
    chk("idle record count", 32'(n), 2);
    chk("idle alerts", 32'(n2), 0);

    // Alert + stuck: 5 identical SBEs in window 0.
    drv(0, 0, 0, 0, 1, 1);
    n = 0; n2 = 0;
    for (int i = 0; i < 32; i++) begin
      drv(i < 5, 0, 8'h07, 0, 1, 0);
      n += int'(sa[0]);
      if (rv[0]) begin
        n2++;
        chk("stuck rec sbe", 32'(rs[0]), (n2 == 1) ? 5 : 0);
        chk("stuck rec flag", 32'(stk[0]), (n2 == 1) ? 1 : 0);
        chk("stuck rec syn", 32'(ry[0]), 32'h07);
      end
    end
    chk("sbe_alert pulses", 32'(n), 1);

    // Priority: both flags high on every other SBE.
    drv(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) drv(1, i[0], 8'($urandom_range(0, 255)), 0, 1, 0);
    chk("prio rec sbe", 32'(rs[0]), 8);
    chk("prio rec dbe", 32'(rd[0]), 8);
    chk("prio dbe_alert", 32'(da[0]), 1);

    // Overflow: 17 SBEs fit inside one 32-cycle window.
    drv(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 32; i++) drv(i < 17, 0, 8'($urandom_range(0, 3)), 0, 1, 0);
    chk("ovf32 rec sbe", 32'(rs[1]), 15);
    chk("ovf32 rec overflow", 32'(ovf[1]), 1);

    // Backpressure across three closes, then ready on a tc cycle.
    drv(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 48; i++) begin
      drv($urandom_range(0, 1), 0, 8'($urandom_range(0, 3)), 0, 0, 0);
      if (i == 15) saved = int'({ry[0], rs[0]});
    end
    chk("bp drop_cnt", 32'(dc[0]), 2);
    chk("bp record held", 32'({ry[0], rs[0]}), 32'(saved));
    for (int i = 0; i < 15; i++) drv(0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 0);
    chk("bp tc rec_valid", 32'(rv[0]), 1);
    chk("bp tc drop_cnt", 32'(dc[0]), 2);

    // tc boundary: SBE on the last cycle of window 0 and first of window 1.
    drv(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 15; i++) drv(0, 0, 0, 0, 1, 0);
    drv(1, 0, 8'h11, 0, 1, 0);
    chk("tc win0 sbe", 32'(rs[0]), 1);
    drv(1, 0, 8'h22, 0, 1, 0);
    for (int i = 0; i < 15; i++) drv(0, 0, 0, 0, 1, 0);
    chk("tc win1 valid", 32'(rv[0]), 1);
    chk("tc win1 sbe", 32'(rs[0]), 1);

    // Clear with pending record, then reset while FULL.
    drv(0, 0, 0, 0, 1, 1);
    drv(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 63; i++) drv(0, 0, 0, 0, 0, 0);
    chk("pre-clear drop_cnt", 32'(dc[0]), 3);
    saved = int'({rd[0], rs[0]});
    drv(0, 0, 0, 1, 0, 0);
    chk("clear dbe_alert", 32'(da[0]), 0);
    chk("clear drop_cnt", 32'(dc[0]), 0);
    chk("clear record kept", 32'({rd[0], rs[0]}), 32'(saved));
    for (int i = 0; i < 15; i++) drv(0, 0, 0, 0, 0, 0);
    chk("clear no early close", 32'(dc[0]), 0);
    drv(0, 0, 0, 0, 0, 0);
    chk("clear timer restart", 32'(dc[0]), 1);
    drv(0, 0, 0, 0, 0, 1);
    chk("rst while full", 32'(rv[0]), 0);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 400; i++)
      drv($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
          8'($urandom_range(0, 3)), $urandom_range(0, 60) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 300) == 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ecc_telemetry_collector.md
Name: ecc_telemetry_collector

Overview:
- Consumer end of the ECC engine telemetry interface (`ml_syndrome`, `ml_err_sbe`, `ml_err_dbe`).
- Aggregates per-read error events over fixed time windows and detects repeated identical SBE syndromes (stuck-bit signature).
- Publishes one summary record per window to the ML engine over a valid/ready handshake, and raises alert outputs for firmware.

Parameters:
- ECC_WIDTH, 8, syndrome width.
- CNT_WIDTH, 16, width of the SBE and DBE window counters.
- WINDOW_CYCLES, 1024, window length in clk cycles (≥2).
- SBE_ALERT_THRESH, 16, SBE count in one window that fires `sbe_alert` (1..2^CNT_WIDTH-1).
- REPEAT_THRESH, 4, consecutive identical SBE syndromes that mark a stuck bit (≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ml_syndrome  in  ECC_WIDTH  syndrome of current read; meaningful only when an error flag is high.
- ml_err_sbe  in  1  single-bit-error event, one cycle per read.
- ml_err_dbe  in  1  double-bit-error event, one cycle per read.
- clear  in  1  software clear of statistics.
- rec_valid  out  1  summary record available.
- rec_ready  in  1  ML engine accepts record.
- rec_sbe_cnt  out  CNT_WIDTH  SBEs in the window.
- rec_dbe_cnt  out  CNT_WIDTH  DBEs in the window.
- rec_syndrome  out  ECC_WIDTH  last SBE syndrome seen at window close.
- rec_stuck  out  1  repeat threshold reached during the window.
- rec_overflow  out  1  a counter saturated during the window.
- sbe_alert  out  1  one-cycle pulse.
- dbe_alert  out  1  sticky DBE indicator.
- drop_cnt  out  8  records lost to backpressure, saturating.

Behaviour:
- **Reset:** `rst` sampled at posedge clears every register. All outputs read 0, including `rec_valid`, `drop_cnt` and `dbe_alert`. The window timer restarts at 0.
  - Reset mid-handshake discards the pending record with no drop counted.
- **Window timer:**
  - Counts 0..WINDOW_CYCLES-1 and wraps.
  - Terminal count (tc) is the cycle the timer equals WINDOW_CYCLES-1; the window closes on that edge.
  - An event on the tc cycle belongs to the closing window.
- **Event qualification:**
  - `sbe` = `ml_err_sbe` & !`ml_err_dbe`; `dbe` = `ml_err_dbe`. Both high counts as DBE only.
  - `ml_syndrome` is ignored when neither flag is high.
- **Counters:**
  - Window SBE/DBE counters increment by 1 per event and saturate at all-ones.
  - A saturating increment attempt sets the window overflow flag.
  - On close, counters, the overflow flag and the stuck flag restart at 0 for the next window; a tc-cycle event is already counted in the closed window.
- **Repeat tracker:**
  - Holds `last_syn` and `rep_cnt` (saturating at REPEAT_THRESH).
  - On `sbe`: if `ml_syndrome` == `last_syn` and `rep_cnt` != 0, increment `rep_cnt`; else load `last_syn` = `ml_syndrome`, `rep_cnt` = 1.
  - When the new `rep_cnt` equals REPEAT_THRESH, set the window stuck flag.
  - DBE does not touch the tracker.
  - `last_syn` and `rep_cnt` persist across windows; only the stuck flag is per-window.
- **sbe_alert:** pulses high for exactly one cycle, the cycle after the window SBE counter transitions to SBE_ALERT_THRESH. At most one pulse per window.
- **dbe_alert:** set the cycle after any `dbe`; stays high until `clear`. Simultaneous `clear` and `dbe` leave it set.
- **Record channel (2-state FSM):**
  - EMPTY: on close, load record registers, go to FULL (`rec_valid`=1).
  - FULL, `rec_ready`=1, no close: go to EMPTY.
  - FULL, `rec_ready`=1 with close in the same cycle: load the new record and stay FULL. No drop.
  - FULL, `rec_ready`=0 with close: keep the old record, increment `drop_cnt` (saturate at 255).
  - Record outputs stay stable while `rec_valid`=1 && !`rec_ready`.
  - Record data outputs hold their last value in EMPTY.
- **clear (synchronous, below rst):**
  - Zeroes the timer, counters, overflow/stuck flags, `last_syn`, `rep_cnt`, `drop_cnt` and `dbe_alert`, and suppresses `sbe_alert` for that cycle.
  - Does not drop or alter a pending record.
  - Events coincident with `clear` are discarded, except for `dbe_alert` as above.

Test Plan:
- Bench settings: WINDOW_CYCLES=16, SBE_ALERT_THRESH=3, REPEAT_THRESH=4, CNT_WIDTH=4.
- Idle: reset, `rec_ready`=1, no events for 40 cycles -> two records with all fields 0, `rec_valid` high one cycle each at cycles 16 and 32; no alerts.
- Alert + stuck: 5 SBEs with syndrome 8'h07 in window 0 -> `sbe_alert` single pulse after the 3rd; record {sbe=5, dbe=0, syn=07, stuck=1, overflow=0}. Window 1 with no events -> stuck=0, syn=07.
- Overflow/priority: 16 SBEs with both flags high on every other one -> record {sbe=8, dbe=8}, `dbe_alert`=1. Repeat with 17 SBE-only events over a longer window (WINDOW_CYCLES=32) -> sbe=15, overflow=1.
- Backpressure: `rec_ready`=0 across three window closes -> first record held unchanged, `drop_cnt`=2. Raise `rec_ready` on a tc cycle -> new record loads, `rec_valid` stays 1, `drop_cnt` unchanged.
- tc boundary: SBE on the tc cycle of window 0 and on the first cycle of window 1 -> window 0 sbe=1, window 1 sbe=1.
- Clear/reset: `dbe_alert`=1, FULL record pending, `drop_cnt`=3; pulse `clear` -> `dbe_alert`=0, `drop_cnt`=0, record intact, timer restarts (next close 16 cycles later). Assert `rst` while FULL -> `rec_valid`=0 the next cycle.
